// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_bus_monitor
//  Purpose  : Receiver end of an HD44780-style 8-bit LCD write bus. Decodes
//             bus writes into a 2x16 character shadow buffer and produces
//             command/data event pulses for on-board text checking.
//  Ports    : sys_clk, sys_rst (async, active-high)
//             LCD_DATA[7:0], LCD_RS, LCD_RW, LCD_EN  - raw LCD bus inputs
//             rd_addr[4:0] -> rd_char[7:0]           - registered buffer read
//             cur_index[4:0]                         - current write index
//             data_pulse, data_char[7:0], data_index[4:0] - data write event
//             cmd_pulse, last_cmd[7:0]               - command event
//             busy                                   - CLEAR sweep running
//             overrun                                - sticky dropped-strobe flag
//  Config   : define LCD_MON_OVERRUN_EN to build the overrun detector;
//             without it overrun is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_EN_HIGH = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [4:0] cur_index,
  output logic       data_pulse,
  output logic [7:0] data_char,
  output logic [4:0] data_index,
  output logic       cmd_pulse,
  output logic [7:0] last_cmd,
  output logic       busy,
  output logic       overrun
);

  localparam int             CNT_W   = $clog2(MIN_EN_HIGH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_EN_HIGH);
  localparam logic [7:0]     BLANK   = 8'h20;
  localparam logic [4:0]     LAST_CELL = 5'd31;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers. All bus bits share one chain so EN stays aligned
  // with the RS/RW/DATA values it qualifies.
  // --------------------------------------------------------------------------
  logic [10:0] sync_q [SYNC_STAGES];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {LCD_DATA, LCD_RW, LCD_RS, LCD_EN};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic       en_s;
  logic       rs_s;
  logic       rw_s;
  logic [7:0] data_s;

  assign en_s   = sync_q[SYNC_STAGES-1][0];
  assign rs_s   = sync_q[SYNC_STAGES-1][1];
  assign rw_s   = sync_q[SYNC_STAGES-1][2];
  assign data_s = sync_q[SYNC_STAGES-1][10:3];

  // --------------------------------------------------------------------------
  // EN high-time qualifier. The counter saturates at MIN_EN_HIGH, so on the
  // first low cycle it still holds the length of the preceding high pulse and
  // reaching saturation both proves a falling edge and a long-enough strobe.
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] en_cnt;
  logic             strobe;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      en_cnt <= '0;
    end else if (en_s) begin
      if (en_cnt != CNT_MAX) en_cnt <= en_cnt + 1'b1;
    end else begin
      en_cnt <= '0;
    end
  end

  assign strobe = !en_s && (en_cnt == CNT_MAX) && !rw_s;

  // --------------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------------
  state_t     state;
  state_t     state_next;
  logic [4:0] clr_idx;
  logic [4:0] clr_next;
  logic [4:0] idx_next;
  logic       buf_we;
  logic [4:0] buf_wa;
  logic [7:0] buf_wd;
  logic       data_evt;
  logic       cmd_evt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state, buffer write port and event decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    clr_next   = clr_idx;
    idx_next   = cur_index;
    buf_we     = 1'b0;
    buf_wa     = cur_index;
    buf_wd     = data_s;
    data_evt   = 1'b0;
    cmd_evt    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (strobe) begin
          if (rs_s) begin
            buf_we   = 1'b1;
            data_evt = 1'b1;
            idx_next = cur_index + 5'd1;   // wraps 15->16 and 31->0 naturally
          end else begin
            cmd_evt = 1'b1;
            if (data_s == 8'h01) begin
              idx_next   = '0;
              clr_next   = '0;
              state_next = ST_CLEAR;
            end else if (data_s[7:1] == 7'b000_0001) begin
              idx_next = '0;
            end else if (data_s[7]) begin
              // Set DDRAM address: only the two visible 16-char windows map.
              if (data_s[6:4] == 3'b000)      idx_next = {1'b0, data_s[3:0]};
              else if (data_s[6:4] == 3'b100) idx_next = {1'b1, data_s[3:0]};
            end
          end
        end
      end

      ST_CLEAR: begin
        // Any strobe arriving here is dropped on purpose.
        buf_we   = 1'b1;
        buf_wa   = clr_idx;
        buf_wd   = BLANK;
        clr_next = clr_idx + 5'd1;
        if (clr_idx == LAST_CELL) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_CLEAR);

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [7:0] buffer [32];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < 32; i++) buffer[i] <= BLANK;
      rd_char    <= BLANK;
      cur_index  <= '0;
      clr_idx    <= '0;
      data_pulse <= 1'b0;
      cmd_pulse  <= 1'b0;
      data_char  <= BLANK;
      data_index <= '0;
      last_cmd   <= 8'h00;
    end else begin
      if (buf_we) buffer[buf_wa] <= buf_wd;
      // Reads see the pre-write contents; no bypass of a same-cycle write.
      rd_char    <= buffer[rd_addr];
      cur_index  <= idx_next;
      clr_idx    <= clr_next;
      data_pulse <= data_evt;
      cmd_pulse  <= cmd_evt;
      if (data_evt) begin
        data_char  <= data_s;
        data_index <= cur_index;
      end
      if (cmd_evt) last_cmd <= data_s;
    end
  end

  // --------------------------------------------------------------------------
  // Optional overrun detector: an accepted strobe that cannot be serviced
  // (during CLEAR) or that lands while the previous event pulse is still high.
  // --------------------------------------------------------------------------
`ifdef LCD_MON_OVERRUN_EN
  logic ovr_evt;
  assign ovr_evt = strobe && (busy || data_pulse || cmd_pulse);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)      overrun <= 1'b0;
    else if (ovr_evt) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

endmodule
`default_nettype wire
